// File: rtl/ether_tx_scheduler.sv
// Round-robin scheduler sharing one RMII frame transmitter between several dibit payload sources.
// It aligns each payload to the transmitter's data request, zero-pads short frames and
// enforces an inter-frame holdoff.
module ether_tx_scheduler #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned REQ_TO_DATA = 8,    // must be >= 2
  parameter int unsigned REQ_TIMEOUT = 255,
  parameter int unsigned HOLDOFF     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_req_i,
  input  logic [11*NUM_SRC-1:0]  src_len_i,
  input  logic [NUM_SRC-1:0]     src_valid_i,
  input  logic [2*NUM_SRC-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]     src_ready_o,
  output logic [NUM_SRC-1:0]     src_grant_o,
  output logic [NUM_SRC-1:0]     src_done_o,
  output logic                   tx_start_o,
  input  logic                   tx_data_request_i,
  output logic                   tx_axiiv_o,
  output logic [1:0]             tx_axiid_o,
  output logic                   busy_o,
  output logic                   underrun_o,
  output logic                   timeout_err_o,
  output logic [15:0]            frame_count_o
);

  localparam int unsigned SelW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {
    StIdle, StStart, StWaitReq, StAlign, StStream, StHoldoff
  } state_e;

  state_e state_q, state_d;

  logic [SelW-1:0]    sel_q, sel_d, ptr_q, ptr_d;
  logic [NUM_SRC-1:0] grant_q, grant_d, done_q, done_d;
  logic [10:0]        len_q, len_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [12:0]        idx_q, idx_d;
  logic               underrun_q, underrun_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic            arb_found;
  logic [SelW-1:0] arb_sel;
  logic [10:0]     arb_len;
  logic            sel_valid;
  logic [1:0]      sel_data;
  logic [10:0]     pad_len;
  logic [12:0]     data_dibits;
  logic [12:0]     last_idx;
  logic            in_data;
  logic            wait_expired;

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    int unsigned k;
    k         = 0;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      k = 32'(ptr_q) + off;
      if (k >= NUM_SRC) k = k - NUM_SRC;
      if (!arb_found && src_req_i[SelW'(k)]) begin
        arb_found = 1'b1;
        arb_sel   = SelW'(k);
      end
    end
  end

  always_comb begin
    arb_len   = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SelW'(i) == arb_sel) arb_len = src_len_i[11*i +: 11];
      if (SelW'(i) == sel_q) begin
        sel_valid = src_valid_i[i];
        sel_data  = src_data_i[2*i +: 2];
      end
    end
  end

  assign pad_len      = (len_q < 11'(MIN_PAYLOAD)) ? 11'(MIN_PAYLOAD) : len_q;
  assign data_dibits  = {len_q, 2'b00};
  assign last_idx     = {pad_len, 2'b00} - 13'd1;
  assign in_data      = idx_q < data_dibits;
  assign wait_expired = cnt_q == 16'(REQ_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arb_found) state_d = StStart;
      StStart:   state_d = StWaitReq;
      StWaitReq: begin
        if (tx_data_request_i) state_d = StAlign;
        else if (wait_expired) state_d = StHoldoff;
      end
      // Leaving on count 1 lands the first dibit REQ_TO_DATA cycles after the request.
      StAlign:   if (cnt_q <= 16'd1) state_d = StStream;
      StStream:  if (idx_q == last_idx) state_d = StHoldoff;
      StHoldoff: if (cnt_q == 16'(HOLDOFF - 1)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    done_d      = '0;
    len_d       = len_q;
    cnt_d       = cnt_q + 16'd1;
    idx_d       = idx_q;
    underrun_d  = underrun_q;
    timeout_d   = timeout_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          sel_d   = arb_sel;
          ptr_d   = arb_sel;
          grant_d = NUM_SRC'(1) << arb_sel;
          len_d   = (arb_len > 11'(MAX_PAYLOAD)) ? 11'(MAX_PAYLOAD) : arb_len;
        end
      end
      StStart: cnt_d = '0;
      StWaitReq: begin
        if (tx_data_request_i) begin
          cnt_d = 16'(REQ_TO_DATA - 1);
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          done_d    = grant_q;
          grant_d   = '0;
          cnt_d     = '0;
        end
      end
      StAlign: begin
        cnt_d = cnt_q - 16'd1;
        idx_d = '0;
      end
      StStream: begin
        idx_d = idx_q + 13'd1;
        if (in_data && !sel_valid) underrun_d = 1'b1;
        if (idx_q == last_idx) begin
          done_d      = grant_q;
          grant_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          cnt_d       = '0;
        end
      end
      StHoldoff: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      ptr_q       <= SelW'(NUM_SRC - 1);
      grant_q     <= '0;
      done_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      underrun_q  <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      underrun_q  <= underrun_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    src_grant_o   = grant_q;
    src_done_o    = done_q;
    tx_start_o    = state_q == StStart;
    busy_o        = state_q != StIdle;
    underrun_o    = underrun_q;
    timeout_err_o = timeout_q;
    frame_count_o = frame_cnt_q;
    src_ready_o   = '0;
    tx_axiiv_o    = 1'b0;
    tx_axiid_o    = 2'b00;
    if (state_q == StStream) begin
      tx_axiiv_o = 1'b1;
      if (in_data) begin
        src_ready_o = grant_q;
        if (sel_valid) tx_axiid_o = sel_data;
      end
    end
  end

endmodule

// File: tb/tb_ether_tx_scheduler.sv
// Directed bench for ether_tx_scheduler: ramp sources, a scripted transmitter and
// hand-derived expectations for arbitration, alignment, padding, underrun, timeout and reset.
module tb_ether_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_req;
  logic [21:0] src_len;
  logic [1:0]  src_valid;
  logic [3:0]  src_data;
  logic [1:0]  src_ready;
  logic [1:0]  src_grant;
  logic [1:0]  src_done;
  logic        tx_start;
  logic        tx_data_request;
  logic        tx_axiiv;
  logic [1:0]  tx_axiid;
  logic        busy;
  logic        underrun;
  logic        timeout_err;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_no = 0;
  int last_end = 0;
  int src_pos[2];
  int mpos[2];

  always #5 clk = ~clk;

  ether_tx_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .src_req_i         (src_req),
    .src_len_i         (src_len),
    .src_valid_i       (src_valid),
    .src_data_i        (src_data),
    .src_ready_o       (src_ready),
    .src_grant_o       (src_grant),
    .src_done_o        (src_done),
    .tx_start_o        (tx_start),
    .tx_data_request_i (tx_data_request),
    .tx_axiiv_o        (tx_axiiv),
    .tx_axiid_o        (tx_axiid),
    .busy_o            (busy),
    .underrun_o        (underrun),
    .timeout_err_o     (timeout_err),
    .frame_count_o     (frame_count)
  );

  function automatic logic [1:0] ramp(input int pos, input int src);
    return 2'((pos ^ (pos >> 2)) + src);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sources consume on the edge when ready&valid; inputs for the new cycle settle 1ns after negedge.
  task automatic next_cycle(input logic [1:0] vld);
    for (int i = 0; i < 2; i++) if (src_ready[i] && src_valid[i]) src_pos[i]++;
    @(negedge clk);
    cycle_no++;
    src_valid = vld;
    for (int i = 0; i < 2; i++) src_data[2*i +: 2] = ramp(src_pos[i], i);
    #1;
  endtask

  task automatic frame(input int src, input int eff_len, input int req_wait, input int gap_at,
                       input int gap_n, input int exp_fc, input logic exp_ur,
                       input logic drop, input logic chk_gap);
    int n, lat, bad, rdy, total, dlen;
    logic [1:0] onehot, exp_rdy, ed, vld;
    onehot = 2'(1 << src);
    dlen   = eff_len * 4;
    total  = ((eff_len < 46) ? 46 : eff_len) * 4;
    n = 0;
    while (tx_start !== 1'b1 && n < 500) begin
      next_cycle(2'b11);
      n++;
    end
    chk("tx_start", 32'(tx_start), 1);
    chk("grant", 32'(src_grant), 32'(onehot));
    if (chk_gap) chk("grant_gap", cycle_no - last_end, 65);
    if (drop) src_req = src_req & ~onehot;
    next_cycle(2'b11);
    chk("start_pulse", 32'(tx_start), 0);
    for (int i = 1; i < req_wait; i++) next_cycle(2'b11);
    tx_data_request = 1'b1;
    next_cycle(2'b11);
    tx_data_request = 1'b0;
    lat = 1;
    while (tx_axiiv !== 1'b1 && lat < 20) begin
      next_cycle(2'b11);
      lat++;
    end
    chk("req_to_data", lat, 8);
    bad = 0;
    rdy = 0;
    for (n = 0; n < total; n++) begin
      if (n < dlen) begin
        exp_rdy = onehot;
        if (n >= gap_at && n < gap_at + gap_n) ed = 2'b00;
        else begin
          ed = ramp(mpos[src], src);
          mpos[src]++;
        end
      end else begin
        exp_rdy = 2'b00;
        ed      = 2'b00;
      end
      if (tx_axiiv !== 1'b1 || tx_axiid !== ed || src_ready !== exp_rdy) bad++;
      if (src_ready[src] === 1'b1) rdy++;
      vld = (n + 1 >= gap_at && n + 1 < gap_at + gap_n) ? ~onehot : 2'b11;
      next_cycle(vld);
    end
    chk("stream_bad_dibits", bad, 0);
    chk("ready_cycles", rdy, dlen);
    chk("axiiv_end", 32'(tx_axiiv), 0);
    chk("done_pulse", 32'(src_done), 32'(onehot));
    chk("grant_clear", 32'(src_grant), 0);
    chk("frame_count", 32'(frame_count), exp_fc);
    chk("underrun", 32'(underrun), 32'(exp_ur));
    last_end = cycle_no;
    next_cycle(2'b11);
    chk("done_one_cycle", 32'(src_done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic axv;
    rst = 1'b1;
    src_req = 2'b00;
    src_len = {11'd10, 11'd46};
    src_valid = 2'b11;
    src_data = '0;
    tx_data_request = 1'b0;
    src_pos[0] = 0; src_pos[1] = 0;
    mpos[0] = 0; mpos[1] = 0;
    for (int i = 0; i < 3; i++) next_cycle(2'b11);
    chk("rst_outs", {src_ready, src_grant, src_done, tx_start, tx_axiiv, tx_axiid}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {underrun, timeout_err, frame_count}, 0);
    rst = 1'b0;
    next_cycle(2'b11);
    chk("idle_no_req", 32'(busy), 0);

    // 1: src0, 46 bytes, ramp payload
    src_req = 2'b01;
    frame(0, 46, 3, -1, 0, 1, 1'b0, 1'b1, 1'b0);
    // 2: src1, 10 bytes then padding
    src_req = 2'b10;
    frame(1, 10, 1, -1, 0, 2, 1'b0, 1'b1, 1'b1);
    // 3: both requesting continuously, alternate grants
    src_len = {11'd46, 11'd46};
    src_req = 2'b11;
    frame(0, 46, 2, -1, 0, 3, 1'b0, 1'b0, 1'b1);
    frame(1, 46, 2, -1, 0, 4, 1'b0, 1'b0, 1'b1);
    frame(0, 46, 2, -1, 0, 5, 1'b0, 1'b0, 1'b1);
    src_req = 2'b10;
    frame(1, 46, 2, -1, 0, 6, 1'b0, 1'b1, 1'b1);
    // 4: three missing dibits mid-payload
    src_len = {11'd46, 11'd20};
    src_req = 2'b01;
    frame(0, 20, 2, 30, 3, 7, 1'b1, 1'b1, 1'b1);

    // 5: transmitter never requests data
    src_req = 2'b01;
    n = 0;
    while (tx_start !== 1'b1 && n < 500) begin
      next_cycle(2'b11);
      n++;
    end
    chk("to_start", 32'(tx_start), 1);
    src_req = 2'b00;
    n = 0;
    axv = 1'b0;
    while (timeout_err !== 1'b1 && n < 400) begin
      next_cycle(2'b11);
      n++;
      if (tx_axiiv !== 1'b0) axv = 1'b1;
    end
    chk("timeout_cycles", n, 256);
    chk("timeout_done", 32'(src_done), 1);
    chk("timeout_grant", 32'(src_grant), 0);
    chk("timeout_no_axiiv", 32'(axv), 0);
    chk("timeout_fc", 32'(frame_count), 7);
    next_cycle(2'b11);
    chk("timeout_done_1cyc", 32'(src_done), 0);

    // 6: reset 20 dibits into a stream
    src_req = 2'b10;
    src_len = {11'd46, 11'd2000};
    n = 0;
    while (tx_start !== 1'b1 && n < 500) begin
      next_cycle(2'b11);
      n++;
    end
    chk("rst6_grant", 32'(src_grant), 2);
    src_req = 2'b00;
    next_cycle(2'b11);
    tx_data_request = 1'b1;
    next_cycle(2'b11);
    tx_data_request = 1'b0;
    n = 0;
    while (tx_axiiv !== 1'b1 && n < 20) begin
      next_cycle(2'b11);
      n++;
    end
    for (int i = 0; i < 20; i++) next_cycle(2'b11);
    chk("rst6_streaming", 32'(src_ready), 2);
    rst = 1'b1;
    next_cycle(2'b11);
    chk("rst6_outs", {src_ready, src_grant, src_done, tx_start, tx_axiiv, tx_axiid}, 0);
    chk("rst6_busy", 32'(busy), 0);
    chk("rst6_flags", {underrun, timeout_err, frame_count}, 0);
    rst = 1'b0;
    src_pos[1] = 0;
    mpos[1] = 0;

    // 7: oversize length clamps to 1500 bytes; pointer reset favours src0
    src_req = 2'b11;
    frame(0, 1500, 2, -1, 0, 1, 1'b0, 1'b1, 1'b0);
    src_req = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
